prepare_batch_datap: RTL

- Replica-side Prepare datapath that accepts batched Prepare messages of 1..BATCH_MAX log entries and appends them to the header log and data log.
- Keeps replica VR state (view, last_op, log head/tail pointers) in internal registers, checks log space per entry, and emits one PrepareOK-class response per batch.
- Sits between the message-manage stage (batch header, entry-length and data streams in) and the UDP transmit stage (response out). Log memories are external and write-only from this block.

---
 rtl/prepare_batch_datap.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/prepare_batch_datap.sv
// Replica Prepare datapath: appends batched entries to the header/data logs
// and answers each batch with a single PrepareOK-class response.
module prepare_batch_datap #(
    parameter int NOC_DATA_W      = 512,
    parameter int LOG_DEPTH_W     = 10,
    parameter int LOG_HDR_DEPTH_W = 8,
    parameter int BATCH_MAX       = 8,
    parameter int VIEW_W          = 64,
    parameter int OPNUM_W         = 64,
    parameter int LEN_W           = 16,
    parameter int CNT_W           = $clog2(BATCH_MAX + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_wr_en,
    input  logic [VIEW_W-1:0]          cfg_view,
    input  logic [OPNUM_W-1:0]         cfg_last_op,
    input  logic                       bat_val,
    output logic                       bat_rdy,
    input  logic [VIEW_W-1:0]          bat_view,
    input  logic [OPNUM_W-1:0]         bat_opnum,
    input  logic [CNT_W-1:0]           bat_count,
    input  logic                       len_val,
    output logic                       len_rdy,
    input  logic [LEN_W-1:0]           len_bytes,
    input  logic                       data_val,
    output logic                       data_rdy,
    input  logic [NOC_DATA_W-1:0]      data_line,
    output logic                       log_data_wr_en,
    output logic [LOG_DEPTH_W-1:0]     log_data_wr_addr,
    output logic [NOC_DATA_W-1:0]      log_data_wr_data,
    output logic                       log_hdr_wr_en,
    output logic [LOG_HDR_DEPTH_W-1:0] log_hdr_wr_addr,
    output logic [VIEW_W+OPNUM_W+LOG_DEPTH_W+LEN_W-1:0] log_hdr_wr_data,
    input  logic                       rel_val,
    input  logic [LOG_HDR_DEPTH_W:0]   rel_hdr_cnt,
    input  logic [LOG_DEPTH_W:0]       rel_line_cnt,
    output logic                       resp_val,
    input  logic                       resp_rdy,
    output logic                       resp_ok,
    output logic [VIEW_W-1:0]          resp_view,
    output logic [OPNUM_W-1:0]         resp_opnum,
    output logic                       err_oversize
);

    localparam int BPL_W = $clog2(NOC_DATA_W / 8);
    localparam int DP_W  = LOG_DEPTH_W + 1;
    localparam int HP_W  = LOG_HDR_DEPTH_W + 1;
    localparam logic [DP_W-1:0] DEPTH = {1'b1, {LOG_DEPTH_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE, CHECK, LEN, DATA, DRAIN_LEN, DRAIN_DATA, RESP
    } state_t;

    state_t state, state_nxt;

    logic [VIEW_W-1:0]  curr_view, b_view;
    logic [OPNUM_W-1:0] last_op, b_opnum, op_cur;
    logic [CNT_W-1:0]   b_count, remaining;
    logic [HP_W-1:0]    hdr_head, hdr_tail;
    logic [DP_W-1:0]    data_head, data_tail;
    logic [LEN_W-1:0]   lines_left;
    logic               failed;

    logic [LEN_W:0]     len_round;
    logic [LEN_W-1:0]   lines;
    logic [DP_W-1:0]    data_used, data_free;
    logic               space_ok, oversize, hdr_full, batch_ok;

    // Ceiling division by the line size in bytes
    assign len_round = {1'b0, len_bytes}
                     + {{(LEN_W + 1 - BPL_W){1'b0}}, {BPL_W{1'b1}}};
    assign lines     = LEN_W'(len_round >> BPL_W);

    assign data_used = data_tail - data_head;
    assign data_free = DEPTH - data_used;
    assign space_ok  = 32'(lines) <= 32'(data_free);
    assign oversize  = 32'(lines) > 32'(DEPTH);
    assign hdr_full  = (hdr_tail[LOG_HDR_DEPTH_W] != hdr_head[LOG_HDR_DEPTH_W])
                    && (hdr_tail[LOG_HDR_DEPTH_W-1:0] == hdr_head[LOG_HDR_DEPTH_W-1:0]);
    assign batch_ok  = (b_view == curr_view)
                    && (b_opnum == last_op + OPNUM_W'(1))
                    && (b_count != '0);

    assign log_hdr_wr_addr  = hdr_tail[LOG_HDR_DEPTH_W-1:0];
    assign log_hdr_wr_data  = {b_view, op_cur, data_tail[LOG_DEPTH_W-1:0], len_bytes};
    assign log_data_wr_addr = data_tail[LOG_DEPTH_W-1:0];
    assign log_data_wr_data = data_line;

    assign resp_val   = (state == RESP);
    assign resp_ok    = resp_val && !failed;
    assign resp_view  = !resp_val ? '0 : (failed ? curr_view : b_view);
    assign resp_opnum = resp_val ? last_op : '0;

    always_comb begin
        state_nxt      = state;
        bat_rdy        = 1'b0;
        len_rdy        = 1'b0;
        data_rdy       = 1'b0;
        log_hdr_wr_en  = 1'b0;
        log_data_wr_en = 1'b0;
        err_oversize   = 1'b0;
        unique case (state)
            IDLE: begin
                bat_rdy = rst_n && !cfg_wr_en;
                if (bat_val && bat_rdy) state_nxt = CHECK;
            end
            CHECK: state_nxt = batch_ok ? LEN : DRAIN_LEN;
            LEN: begin
                len_rdy = oversize || (space_ok && !hdr_full);
                if (len_val && len_rdy) begin
                    if (oversize) begin
                        err_oversize = 1'b1;
                        state_nxt    = DRAIN_DATA;
                    end else begin
                        log_hdr_wr_en = 1'b1;
                        if (lines != '0) state_nxt = DATA;
                        else if (remaining == CNT_W'(1)) state_nxt = RESP;
                    end
                end
            end
            DATA: begin
                data_rdy       = 1'b1;
                log_data_wr_en = data_val;
                if (data_val && lines_left == LEN_W'(1))
                    state_nxt = (remaining == CNT_W'(1)) ? RESP : LEN;
            end
            DRAIN_LEN: begin
                if (remaining == '0) begin
                    state_nxt = RESP;
                end else begin
                    len_rdy = 1'b1;
                    if (len_val && lines != '0) state_nxt = DRAIN_DATA;
                end
            end
            DRAIN_DATA: begin
                data_rdy = 1'b1;
                if (data_val && lines_left == LEN_W'(1)) state_nxt = DRAIN_LEN;
            end
            RESP: if (resp_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            curr_view  <= '0;
            last_op    <= '0;
            b_view     <= '0;
            b_opnum    <= '0;
            b_count    <= '0;
            op_cur     <= '0;
            remaining  <= '0;
            lines_left <= '0;
            failed     <= 1'b0;
            hdr_head   <= '0;
            hdr_tail   <= '0;
            data_head  <= '0;
            data_tail  <= '0;
        end else begin
            state <= state_nxt;
            if (rel_val) begin
                hdr_head  <= hdr_head + rel_hdr_cnt;
                data_head <= data_head + rel_line_cnt;
            end
            case (state)
                IDLE: begin
                    if (cfg_wr_en) begin
                        curr_view <= cfg_view;
                        last_op   <= cfg_last_op;
                    end else if (bat_val) begin
                        b_view  <= bat_view;
                        b_opnum <= bat_opnum;
                        b_count <= bat_count;
                    end
                end
                CHECK: begin
                    remaining <= b_count;
                    op_cur    <= b_opnum;
                    failed    <= !batch_ok;
                end
                LEN: if (len_val && len_rdy) begin
                    lines_left <= lines;
                    if (oversize) begin
                        failed    <= 1'b1;
                        remaining <= remaining - CNT_W'(1);
                    end else begin
                        hdr_tail <= hdr_tail + HP_W'(1);
                        if (lines == '0) begin
                            last_op   <= op_cur;
                            op_cur    <= op_cur + OPNUM_W'(1);
                            remaining <= remaining - CNT_W'(1);
                        end
                    end
                end
                DATA: if (data_val) begin
                    data_tail  <= data_tail + DP_W'(1);
                    lines_left <= lines_left - LEN_W'(1);
                    if (lines_left == LEN_W'(1)) begin
                        last_op   <= op_cur;
                        op_cur    <= op_cur + OPNUM_W'(1);
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                DRAIN_LEN: if (len_val && len_rdy) begin
                    lines_left <= lines;
                    remaining  <= remaining - CNT_W'(1);
                end
                DRAIN_DATA: if (data_val) lines_left <= lines_left - LEN_W'(1);
                default: ;
            endcase
        end
    end

endmodule
